// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Shares the system bus between the CPU (requester 0, default
//               owner) and up to three bus-master peripherals. Ownership only
//               changes at CPU instruction boundaries, with a one-cycle idle
//               turnaround each way. The CPU is stalled while a peripheral
//               owns the bus.
// Ports       : clk, reset (async, active-low), clk_ce (CPU-rate enable),
//               cpu_sync (CPU at instruction boundary),
//               req/ack (per-requester request/grant), cpu_hold (CPU stall),
//               m_* (per-requester bus slices), address_out/data_out/read/
//               write/bus_status (muxed bus), owner (current owner index),
//               overrun (sticky hold-time violation flag)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int          N_REQ    = 3,
  parameter int          RR_MODE  = 0,
  parameter logic [15:0] MAX_HOLD = 16'd4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_ce,
  input  logic                 cpu_sync,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     ack,
  output logic                 cpu_hold,
  input  logic [N_REQ*24-1:0]  m_address,
  input  logic [N_REQ*8-1:0]   m_data,
  input  logic [N_REQ-1:0]     m_read,
  input  logic [N_REQ-1:0]     m_write,
  input  logic [N_REQ*2-1:0]   m_bus_status,
  output logic [23:0]          address_out,
  output logic [7:0]           data_out,
  output logic                 read,
  output logic                 write,
  output logic [1:0]           bus_status,
  output logic [1:0]           owner,
  output logic                 overrun
);

  localparam logic [1:0] c_OWN_CPU = 2'd0;
  localparam logic [1:0] c_TURN    = 2'd1;
  localparam logic [1:0] c_OWN_P   = 2'd2;
  localparam logic [1:0] c_RET     = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_sel;
  logic [1:0]  r_last;
  logic [15:0] r_hold_cnt;
  logic        r_overrun;

  logic        w_any_req;
  logic        w_req_sel;
  logic [1:0]  w_win;
  logic [15:0] w_cnt_inc;
  logic [1:0]  w_src;
  logic        w_bus_en;
  int          w_dist;
  int          w_best;

  assign w_any_req = |req[N_REQ-1:1];
  assign w_cnt_inc = (r_hold_cnt == 16'hFFFF) ? r_hold_cnt : r_hold_cnt + 16'd1;

  // Request level of the currently selected peripheral.
  always_comb begin
    w_req_sel = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_sel == 2'(i)) w_req_sel = req[i];
    end
  end

  // Winner selection. Round-robin measures each requester's distance upward
  // from the last granted index (wrapping over peripherals only); the
  // closest asserted requester wins.
  always_comb begin
    w_win  = 2'd0;
    w_dist = 0;
    w_best = N_REQ;
    if (RR_MODE == 0) begin
      for (int j = 1; j < N_REQ; j++) begin
        if (req[j]) w_win = 2'(j);
      end
    end else begin
      for (int j = 1; j < N_REQ; j++) begin
        w_dist = j - int'(r_last);
        if (w_dist <= 0) w_dist = w_dist + (N_REQ - 1);
        if (req[j] && (w_dist < w_best)) begin
          w_best = w_dist;
          w_win  = 2'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_OWN_CPU;
      r_sel      <= 2'd0;
      r_last     <= 2'd0;
      r_hold_cnt <= 16'd0;
      r_overrun  <= 1'b0;
    end else if (clk_ce) begin
      case (r_state)
        c_OWN_CPU: begin
          if (cpu_sync && w_any_req) begin
            r_state <= c_TURN;
            r_sel   <= w_win;
          end
        end
        c_TURN: begin
          r_hold_cnt <= 16'd0;
          r_state    <= w_req_sel ? c_OWN_P : c_RET;
        end
        c_OWN_P: begin
          if (w_req_sel) begin
            r_hold_cnt <= w_cnt_inc;
            // Flag only; the grant stays with the peripheral.
            if (w_cnt_inc >= MAX_HOLD) r_overrun <= 1'b1;
          end else begin
            r_state    <= c_RET;
            r_last     <= r_sel;
            r_hold_cnt <= 16'd0;
          end
        end
        c_RET: begin
          r_hold_cnt <= 16'd0;
          // Chain directly to the next peripheral without re-granting the CPU.
          if (w_any_req) begin
            r_state <= c_TURN;
            r_sel   <= w_win;
          end else begin
            r_state <= c_OWN_CPU;
          end
        end
        default: r_state <= c_OWN_CPU;
      endcase
    end
  end

  // Bus source: CPU in OWN_CPU, selected peripheral in OWN_P, idle otherwise.
  assign w_src    = (r_state == c_OWN_P) ? r_sel : 2'd0;
  assign w_bus_en = (r_state == c_OWN_CPU) || (r_state == c_OWN_P);
  assign cpu_hold = (r_state != c_OWN_CPU);
  assign owner    = w_src;
  assign overrun  = r_overrun;

  always_comb begin
    ack         = '0;
    address_out = 24'd0;
    data_out    = 8'd0;
    read        = 1'b0;
    write       = 1'b0;
    bus_status  = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_bus_en && (w_src == 2'(i))) begin
        ack[i]      = 1'b1;
        address_out = m_address[i*24 +: 24];
        data_out    = m_data[i*8 +: 8];
        read        = m_read[i];
        write       = m_write[i];
        bus_status  = m_bus_status[i*2 +: 2];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. Two instances share the
//               stimulus: one fixed-priority, one round-robin, both with a
//               short hold limit. A behavioural model predicts every output
//               each cycle; directed steps add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int N    = 3;
  localparam int MAXH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_ce;
  logic          cpu_sync;
  logic [2:0]    req;
  logic [71:0]   m_address;
  logic [23:0]   m_data;
  logic [2:0]    m_read;
  logic [2:0]    m_write;
  logic [5:0]    m_bus_status;

  logic [2:0]    ack_o  [2];
  logic          hold_o [2];
  logic [23:0]   addr_o [2];
  logic [7:0]    data_o [2];
  logic          rd_o   [2];
  logic          wr_o   [2];
  logic [1:0]    bs_o   [2];
  logic [1:0]    own_o  [2];
  logic          ovr_o  [2];

  int checks = 0;
  int errors = 0;
  logic run_chk = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_REQ(N), .RR_MODE(0), .MAX_HOLD(16'd8)) u_fix (
    .clk(clk), .reset(reset), .clk_ce(clk_ce), .cpu_sync(cpu_sync),
    .req(req), .ack(ack_o[0]), .cpu_hold(hold_o[0]),
    .m_address(m_address), .m_data(m_data), .m_read(m_read), .m_write(m_write),
    .m_bus_status(m_bus_status), .address_out(addr_o[0]), .data_out(data_o[0]),
    .read(rd_o[0]), .write(wr_o[0]), .bus_status(bs_o[0]), .owner(own_o[0]),
    .overrun(ovr_o[0])
  );

  bus_arbiter #(.N_REQ(N), .RR_MODE(1), .MAX_HOLD(16'd8)) u_rr (
    .clk(clk), .reset(reset), .clk_ce(clk_ce), .cpu_sync(cpu_sync),
    .req(req), .ack(ack_o[1]), .cpu_hold(hold_o[1]),
    .m_address(m_address), .m_data(m_data), .m_read(m_read), .m_write(m_write),
    .m_bus_status(m_bus_status), .address_out(addr_o[1]), .data_out(data_o[1]),
    .read(rd_o[1]), .write(wr_o[1]), .bus_status(bs_o[1]), .owner(own_o[1]),
    .overrun(ovr_o[1])
  );

  // ---------------- behavioural model ----------------
  // phase: 0 = CPU owns, 1 = idle before peripheral, 2 = peripheral owns,
  //        3 = idle after peripheral
  int   ph    [2];
  int   psel  [2];
  int   plast [2];
  int   held  [2];
  logic povr  [2];

  function automatic int pick(input int m);
    int idx;
    if (m == 0) begin
      for (int j = N - 1; j >= 1; j--) if (req[j]) return j;
    end else begin
      for (int k = 1; k < N; k++) begin
        idx = plast[m] + k;
        while (idx > N - 1) idx = idx - (N - 1);
        if (req[idx]) return idx;
      end
    end
    return 0;
  endfunction

  task automatic model_step(input int m);
    case (ph[m])
      0: if (cpu_sync && req[2:1] != 2'b00) begin psel[m] = pick(m); ph[m] = 1; end
      1: if (req[psel[m]]) begin ph[m] = 2; held[m] = 0; end else ph[m] = 3;
      2: if (req[psel[m]]) begin
           if (held[m] < 65535) held[m] = held[m] + 1;
           if (held[m] >= MAXH) povr[m] = 1'b1;
         end else begin
           plast[m] = psel[m];
           ph[m] = 3;
         end
      default: if (req[2:1] != 2'b00) begin psel[m] = pick(m); ph[m] = 1; end
               else ph[m] = 0;
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        ph[m] = 0; psel[m] = 0; plast[m] = 0; held[m] = 0; povr[m] = 1'b0;
      end
    end else if (clk_ce) begin
      for (int m = 0; m < 2; m++) model_step(m);
    end
  end

  function automatic int exp_src(input int m);
    if (ph[m] == 0) return 0;
    if (ph[m] == 2) return psel[m];
    return -1;
  endfunction

  task automatic check(input int m, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst%0d] @%0t: got %0h expected %0h", nm, m, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      for (int m = 0; m < 2; m++) begin
        int s;
        s = exp_src(m);
        check(m, "ack",      32'(ack_o[m]),  (s < 0) ? 32'd0 : (32'd1 << s));
        check(m, "cpu_hold", 32'(hold_o[m]), 32'(ph[m] != 0));
        check(m, "overrun",  32'(ovr_o[m]),  32'(povr[m]));
        check(m, "address",  32'(addr_o[m]), (s < 0) ? 32'd0 : 32'(m_address[s*24 +: 24]));
        check(m, "data",     32'(data_o[m]), (s < 0) ? 32'd0 : 32'(m_data[s*8 +: 8]));
        check(m, "rd_wr",    {30'd0, rd_o[m], wr_o[m]},
              (s < 0) ? 32'd0 : {30'd0, m_read[s], m_write[s]});
        check(m, "bus_stat", 32'(bs_o[m]),   (s < 0) ? 32'd0 : 32'(m_bus_status[s*2 +: 2]));
        if (s >= 0) check(m, "owner", 32'(own_o[m]), 32'(s));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic lit_both(input string nm, input logic [2:0] exp_ack);
    check(0, nm, 32'(ack_o[0]), 32'(exp_ack));
    check(1, nm, 32'(ack_o[1]), 32'(exp_ack));
  endtask

  int exp_rr [4] = '{2, 1, 2, 1};

  initial begin
    int got;
    int n;
    reset = 1'b0; clk_ce = 1'b1; cpu_sync = 1'b0; req = 3'b000;
    m_address    = {24'hC22222, 24'hB11111, 24'hA00000};
    m_data       = {8'h32, 8'h21, 8'h10};
    m_read       = 3'b101;
    m_write      = 3'b010;
    m_bus_status = {2'b11, 2'b10, 2'b01};
    step(2);
    run_chk = 1'b1;
    lit_both("reset_ack", 3'b001);
    check(0, "reset_hold", 32'(hold_o[0]), 32'd0);
    reset = 1'b1;
    step(1);

    // Single request, held off until the instruction boundary.
    req = 3'b010;
    step(5);
    lit_both("t1_nosync", 3'b001);
    cpu_sync = 1'b1;
    step(1);
    lit_both("t1_turn", 3'b000);
    check(0, "t1_turn_bs", 32'(bs_o[0]), 32'd0);
    cpu_sync = 1'b0;
    step(1);
    lit_both("t1_grant", 3'b010);
    check(0, "t1_addr", 32'(addr_o[0]), 32'h00B11111);
    check(0, "t1_bs", 32'(bs_o[0]), 32'd2);
    req = 3'b000;
    step(1);
    lit_both("t1_ret", 3'b000);
    step(1);
    lit_both("t1_cpu", 3'b001);
    check(0, "t1_cpu_addr", 32'(addr_o[0]), 32'h00A00000);

    // Simultaneous requests; chained hand-over without a CPU grant.
    req = 3'b110; cpu_sync = 1'b1;
    step(2);
    lit_both("t2_grant2", 3'b100);
    req = 3'b010;
    step(1);
    lit_both("t2_ret", 3'b000);
    step(1);
    lit_both("t2_turn", 3'b000);
    step(1);
    lit_both("t2_grant1", 3'b010);
    req = 3'b000;
    step(2);
    lit_both("t2_cpu", 3'b001);

    // Round-robin alternation (last granted was 1, so 2 comes first).
    req = 3'b110; cpu_sync = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (ack_o[1][2:1] == 2'b00 && n < 8) begin step(1); n++; end
      got = ack_o[1][2] ? 2 : (ack_o[1][1] ? 1 : 0);
      check(1, "rr_grant", 32'(got), 32'(exp_rr[g]));
      step(3);
      req[got] = 1'b0;
      step(1);
      req[got] = 1'b1;
    end
    req = 3'b000; cpu_sync = 1'b0;
    n = 0;
    while ((ack_o[0] != 3'b001 || ack_o[1] != 3'b001) && n < 10) begin step(1); n++; end
    lit_both("rr_back_cpu", 3'b001);

    // Request withdrawn during turnaround.
    req = 3'b010; cpu_sync = 1'b1;
    step(1);
    lit_both("t4_turn", 3'b000);
    req = 3'b000;
    step(1);
    lit_both("t4_ret", 3'b000);
    check(1, "t4_ret_bs", 32'(bs_o[1]), 32'd0);
    step(1);
    lit_both("t4_cpu", 3'b001);
    cpu_sync = 1'b0;

    // Hold-time overrun, with a clock-enable pause inside the grant.
    reset = 1'b0; step(1); reset = 1'b1; step(1);
    req = 3'b100; cpu_sync = 1'b1;
    step(2);
    lit_both("t5_grant", 3'b100);
    cpu_sync = 1'b0;
    step(7);
    check(0, "t5_ovr7", 32'(ovr_o[0]), 32'd0);
    clk_ce = 1'b0;
    step(3);
    check(1, "t5_ovr_ce0", 32'(ovr_o[1]), 32'd0);
    lit_both("t5_ce0_ack", 3'b100);
    clk_ce = 1'b1;
    step(1);
    check(0, "t5_ovr8", 32'(ovr_o[0]), 32'd1);
    check(1, "t5_ovr8", 32'(ovr_o[1]), 32'd1);
    lit_both("t5_kept", 3'b100);
    step(2);
    req = 3'b000;
    step(2);
    lit_both("t5_cpu", 3'b001);
    check(0, "t5_sticky", 32'(ovr_o[0]), 32'd1);

    // Asynchronous reset during a peripheral grant with clk_ce low.
    req = 3'b010; cpu_sync = 1'b1;
    step(2);
    lit_both("t6_grant", 3'b010);
    clk_ce = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    lit_both("t6_rst_ack", 3'b001);
    check(0, "t6_rst_hold", 32'(hold_o[0]), 32'd0);
    check(0, "t6_rst_ovr", 32'(ovr_o[0]), 32'd0);
    step(1);
    req = 3'b000; cpu_sync = 1'b0; reset = 1'b1; clk_ce = 1'b1;
    step(2);
    lit_both("t6_after", 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
